fft_sequencer: RTL and testbench

- Control FSM for an in-place radix-2 DIT FFT built from one shared butterfly datapath (complex multiply plus add/sub) and a single N-entry sample RAM.
- Accepts N input samples and generates bit-reversed write addresses.
- Issues N/2 butterflies per stage over log2(N) stages, with per-butterfly A/B addresses and twiddle ROM index.
- Unloads results in natural order. Sits between the sample-stream interface and the RAM / twiddle ROM / butterfly.

---
 rtl/fft_sequencer_if.sv | 32 +++
 rtl/fft_sequencer.sv | 144 ++++++++++++++
 tb/tb_fft_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sequencer_if.sv
// rtl/fft_sequencer_if.sv - sample-stream, RAM, twiddle and butterfly signals of the FFT sequencer
interface fft_sequencer_if #(
  parameter int N_2 = 5
);
  logic           start;
  logic           in_valid;
  logic           out_ready;
  logic           busy;
  logic           load_we;
  logic [N_2-1:0] load_addr;
  logic           bfly_valid;
  logic [N_2-1:0] addr_a;
  logic [N_2-1:0] addr_b;
  logic [N_2-2:0] tw_addr;
  logic [N_2-1:0] stage;
  logic           rd_en;
  logic [N_2-1:0] rd_addr;
  logic           done;

  // master: the sequencer itself; slave: the environment driving it
  modport master (
    input  start, in_valid, out_ready,
    output busy, load_we, load_addr, bfly_valid, addr_a, addr_b,
           tw_addr, stage, rd_en, rd_addr, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  busy, load_we, load_addr, bfly_valid, addr_a, addr_b,
           tw_addr, stage, rd_en, rd_addr, done
  );
endinterface

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - control FSM for an in-place radix-2 DIT FFT on one butterfly and one RAM
module fft_sequencer #(
  parameter int N_2      = 5,
  parameter int BFLY_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  fft_sequencer_if.master  bus
);
  localparam int N  = 1 << N_2;
  localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [N_2-1:0] CNT_LAST   = N_2'(N - 1);
  localparam logic [N_2-1:0] BFLY_LAST  = N_2'(N / 2 - 1);
  localparam logic [N_2-1:0] STAGE_LAST = N_2'(N_2 - 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'((BFLY_LAT > 0) ? BFLY_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N_2-1:0] cnt_q, cnt_d;
  logic [N_2-1:0] stage_q, stage_d;
  logic [DW-1:0]  drain_q, drain_d;

  logic [N_2-1:0] idx_ext, low_mask, a_addr, rev_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + N_2'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_COMPUTE;
            stage_d = '0;
          end
        end
      end
      S_COMPUTE: begin
        if (cnt_q == BFLY_LAST) begin
          cnt_d = '0;
          if (BFLY_LAT > 0) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else if (stage_q == STAGE_LAST) begin
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage_q + N_2'(1);
          end
        end else begin
          cnt_d = cnt_q + N_2'(1);
        end
      end
      S_DRAIN: begin
        // idle the butterfly so the last write-backs land before the next stage reads
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_UNLOAD;
          end else begin
            state_d = S_COMPUTE;
            stage_d = stage_q + N_2'(1);
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_UNLOAD: begin
        if (bus.out_ready) begin
          cnt_d = cnt_q + N_2'(1);
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // top leg: butterfly index with a zero spliced in at bit position stage
    idx_ext  = {1'b0, cnt_q[N_2-2:0]};
    low_mask = (N_2'(1) << stage_q) - N_2'(1);
    a_addr   = ((idx_ext >> stage_q) << (stage_q + N_2'(1))) | (idx_ext & low_mask);
    rev_addr = '0;
    for (int j = 0; j < N_2; j++) rev_addr[j] = cnt_q[N_2-1-j];

    bus.busy       = (state_q != S_IDLE);
    bus.load_we    = 1'b0;
    bus.load_addr  = '0;
    bus.bfly_valid = 1'b0;
    bus.addr_a     = '0;
    bus.addr_b     = '0;
    bus.tw_addr    = '0;
    bus.stage      = stage_q;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.done       = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.load_we   = bus.in_valid;
        bus.load_addr = rev_addr;
      end
      S_COMPUTE: begin
        bus.bfly_valid = 1'b1;
        bus.addr_a     = a_addr;
        bus.addr_b     = a_addr | (N_2'(1) << stage_q);
        bus.tw_addr    = (N_2-1)'((idx_ext & low_mask) << (STAGE_LAST - stage_q));
      end
      S_UNLOAD: begin
        bus.rd_en   = bus.out_ready;
        bus.rd_addr = cnt_q;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - randomized self-checking bench for fft_sequencer (N_2=3/LAT=2 and N_2=5/LAT=3)
module tb_fft_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic sel, start, in_valid, out_ready;
  int   checks = 0, passed = 0, cyc = 0;
  int   n2, nn, lat, t0, stalls;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_sequencer_if #(.N_2(3)) ifa ();
  fft_sequencer_if #(.N_2(5)) ifb ();

  assign ifa.start     = start & ~sel;
  assign ifa.in_valid  = in_valid & ~sel;
  assign ifa.out_ready = out_ready & ~sel;
  assign ifb.start     = start & sel;
  assign ifb.in_valid  = in_valid & sel;
  assign ifb.out_ready = out_ready & sel;

  fft_sequencer #(.N_2(3), .BFLY_LAT(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  fft_sequencer #(.N_2(5), .BFLY_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic       busy_o, load_we_o, bfly_o, rd_en_o, done_o;
  logic [4:0] load_addr_o, addr_a_o, addr_b_o, tw_o, stage_o, rd_addr_o;

  always_comb begin
    if (sel) begin
      {busy_o, load_we_o, bfly_o, rd_en_o, done_o} =
        {ifb.busy, ifb.load_we, ifb.bfly_valid, ifb.rd_en, ifb.done};
      load_addr_o = ifb.load_addr;
      addr_a_o    = ifb.addr_a;
      addr_b_o    = ifb.addr_b;
      tw_o        = {1'b0, ifb.tw_addr};
      stage_o     = ifb.stage;
      rd_addr_o   = ifb.rd_addr;
    end else begin
      {busy_o, load_we_o, bfly_o, rd_en_o, done_o} =
        {ifa.busy, ifa.load_we, ifa.bfly_valid, ifa.rd_en, ifa.done};
      load_addr_o = {2'b0, ifa.load_addr};
      addr_a_o    = {2'b0, ifa.addr_a};
      addr_b_o    = {2'b0, ifa.addr_b};
      tw_o        = {3'b0, ifa.tw_addr};
      stage_o     = {2'b0, ifa.stage};
      rd_addr_o   = {2'b0, ifa.rd_addr};
    end
  end

  function automatic int bitrev(int v, int w);
    int r = 0;
    for (int j = 0; j < w; j++) if (v & (1 << j)) r |= 1 << (w - 1 - j);
    return r;
  endfunction

  // mode 0: always ready, 1: scripted stalls, 2: random stalls
  function automatic logic in_pat(int mode, int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2 == 0);
    return ($urandom_range(3) != 0);
  endfunction

  function automatic logic out_pat(int mode, int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return !(c >= 1 && c <= 3);
    return ($urandom_range(3) != 0);
  endfunction

  task automatic set_cfg(input logic s);
    sel = s;
    n2  = s ? 5 : 3;
    nn  = 1 << n2;
    lat = s ? 3 : 2;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy_o);
    else passed++;
    t0 = cyc;
    stalls = 0;
  endtask

  task automatic check_load(input int mode);
    int k = 0, c = 0;
    logic v;
    while (k < nn && c < 64 * nn) begin
      @(negedge clk);
      v = in_pat(mode, c);
      start = 1'(($urandom_range(1)));
      in_valid = v;
      #1;
      checks++;
      if ({busy_o, load_we_o, bfly_o, rd_en_o, done_o} !== {1'b1, v, 3'b000})
        $display("FAIL load_ctl k=%0d: got busy/we/bfly/rd/done=%b%b%b%b%b want 1%b000",
                 k, busy_o, load_we_o, bfly_o, rd_en_o, done_o, v);
      else passed++;
      checks++;
      if (load_addr_o !== 5'(bitrev(k, n2)))
        $display("FAIL load_addr k=%0d: got %0d want %0d", k, load_addr_o, bitrev(k, n2));
      else passed++;
      if (v) k++; else stalls++;
      c++;
    end
  endtask

  // reference: for each stage, butterflies pair samples 2**s apart inside groups of 2**(s+1)
  task automatic check_compute();
    for (int s = 0; s < n2; s++) begin
      int half = 1 << s;
      for (int g = 0; g < nn; g += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          @(negedge clk);
          start = 1'(($urandom_range(1)));
          in_valid = 1'(($urandom_range(1)));
          out_ready = 1'(($urandom_range(1)));
          #1;
          checks++;
          if ({bfly_o, load_we_o, rd_en_o, busy_o, done_o} !== 5'b10010)
            $display("FAIL cmp_ctl s=%0d: got bfly/we/rd/busy/done=%b%b%b%b%b want 10010",
                     s, bfly_o, load_we_o, rd_en_o, busy_o, done_o);
          else passed++;
          checks++;
          if ({addr_a_o, addr_b_o, tw_o, stage_o} !==
              {5'(g + j), 5'(g + j + half), 5'(j << (n2 - 1 - s)), 5'(s)})
            $display("FAIL bfly s=%0d: got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                     s, addr_a_o, addr_b_o, tw_o, stage_o, g + j, g + j + half,
                     j << (n2 - 1 - s), s);
          else passed++;
        end
      end
      for (int d = 0; d < lat; d++) begin
        @(negedge clk);
        start = 1'(($urandom_range(1)));
        out_ready = 1'(($urandom_range(1)));
        #1;
        checks++;
        if ({bfly_o, busy_o, rd_en_o, addr_a_o, addr_b_o, tw_o} !== {3'b010, 15'd0})
          $display("FAIL drain s=%0d d=%0d: got bfly=%b busy=%b rd=%b a=%0d b=%0d tw=%0d want 0 1 0 0 0 0",
                   s, d, bfly_o, busy_o, rd_en_o, addr_a_o, addr_b_o, tw_o);
        else passed++;
      end
    end
  endtask

  task automatic check_unload(input int mode);
    int k = 0, c = 0;
    logic r;
    while (k < nn && c < 64 * nn) begin
      @(negedge clk);
      r = out_pat(mode, c);
      start = 1'b0;
      in_valid = 1'(($urandom_range(1)));
      out_ready = r;
      #1;
      checks++;
      if ({busy_o, rd_en_o, load_we_o, bfly_o, done_o} !== {1'b1, r, 3'b000})
        $display("FAIL unload_ctl k=%0d: got busy/rd/we/bfly/done=%b%b%b%b%b want 1%b000",
                 k, busy_o, rd_en_o, load_we_o, bfly_o, done_o, r);
      else passed++;
      checks++;
      if (rd_addr_o !== 5'(k))
        $display("FAIL rd_addr: got %0d want %0d", rd_addr_o, k);
      else passed++;
      if (r) k++; else stalls++;
      c++;
    end
  endtask

  task automatic check_done();
    int exp_lat;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
    #1;
    exp_lat = 1 + nn + n2 * (nn / 2 + lat) + nn + stalls;
    checks++;
    if ({done_o, busy_o} !== 2'b11)
      $display("FAIL done_pulse: got done=%b busy=%b want 1 1", done_o, busy_o);
    else passed++;
    checks++;
    if (cyc - t0 !== exp_lat)
      $display("FAIL done_latency: got %0d cycles want %0d", cyc - t0, exp_lat);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({done_o, busy_o} !== 2'b00)
      $display("FAIL done_end: got done=%b busy=%b want 0 0", done_o, busy_o);
    else passed++;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy_o, load_we_o, bfly_o, rd_en_o, done_o, load_addr_o, addr_a_o,
         addr_b_o, tw_o, stage_o, rd_addr_o} !== 35'd0)
      $display("FAIL %s: got busy=%b we=%b bfly=%b rd=%b done=%b la=%0d a=%0d b=%0d tw=%0d st=%0d ra=%0d want all 0",
               tag, busy_o, load_we_o, bfly_o, rd_en_o, done_o, load_addr_o, addr_a_o,
               addr_b_o, tw_o, stage_o, rd_addr_o);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_cfg(1'b0);
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_a");
    set_cfg(1'b1);
    #1;
    check_all_zero("reset_b");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_cfg(1'b0);
    do_start();
    check_load(0);
    check_compute();
    check_unload(0);
    check_done();
  endtask

  task automatic test_stalls();
    set_cfg(1'b0);
    do_start();
    check_load(1);
    check_compute();
    check_unload(1);
    check_done();
  endtask

  task automatic test_random_small();
    set_cfg(1'b0);
    for (int r = 0; r < 3; r++) begin
      do_start();
      check_load(2);
      check_compute();
      check_unload(2);
      check_done();
    end
  endtask

  task automatic test_n32();
    set_cfg(1'b1);
    for (int m = 0; m < 3; m += 2) begin
      do_start();
      check_load(m);
      check_compute();
      check_unload(m);
      check_done();
    end
  endtask

  task automatic test_abort_rerun();
    logic found = 1'b0;
    set_cfg(1'b0);
    do_start();
    check_load(0);
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      start = 1'b1;
      #1;
      if (bfly_o === 1'b1 && stage_o === 5'd1) found = 1'b1;
      else begin
        checks++;
        if (busy_o !== 1'b1) $display("FAIL start_ignored_busy: got %b want 1", busy_o);
        else passed++;
      end
    end
    checks++;
    if (!found) $display("FAIL reach_stage1: got no stage-1 butterfly want one within 40 cycles");
    else passed++;
    checks++;
    if ({addr_a_o, addr_b_o, tw_o} !== {5'd0, 5'd2, 5'd0})
      $display("FAIL stage1_first: got a=%0d b=%0d tw=%0d want 0 2 0", addr_a_o, addr_b_o, tw_o);
    else passed++;
    #2;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_all_zero("async_abort");
    @(negedge clk);
    reset = 1'b0;
    test_basic();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_random_small();
    test_n32();
    test_abort_rerun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
